// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-entry pending scoreboard and post-reset zeroing sweep.
// Optional same-cycle write-back bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              RST,
   output logic              InitDone,
   input  logic              RegWre,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              IssueValid,
   input  logic [ADDR_W-1:0] IssueReg,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic              ReadPend1,
   output logic              ReadPend2
);

   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam bit          ZERO_EN = (ZERO_REG != 0);

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   cnt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DEPTH-1:0]    pend;
   logic                ready;
   logic                wr_en;
   logic                iss_en;

   // State register; reset restarts the sweep from any state.
   always_ff @(posedge CLK) begin
      if (!RST) state <= INIT;
      else      state <= state_nxt;
   end

   // Next state: leave INIT once the last entry is swept.
   always_comb begin
      state_nxt = state;
      if (state == INIT && cnt == ADDR_W'(DEPTH - 1)) state_nxt = READY;
   end

   // Traffic qualifiers; entry 0 is hardwired when ZERO_REG is set.
   always_comb begin
      ready  = (state == READY);
      wr_en  = ready && RegWre && !(ZERO_EN && WriteReg == '0);
      iss_en = ready && IssueValid && !(ZERO_EN && IssueReg == '0);
   end

   always_ff @(posedge CLK) begin
      if (!RST)        cnt <= '0;
      else if (!ready) cnt <= cnt + ADDR_W'(1);
   end

   // Array has no reset; the sweep zeroes it one entry per cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         if (!ready)     mem[cnt]      <= '0;
         else if (wr_en) mem[WriteReg] <= WriteData;
      end
   end

   // Issue is applied after write-back so a same-register collision stays pending.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         pend <= '0;
      end else if (!ready) begin
         pend[cnt] <= 1'b0;
      end else begin
         if (wr_en)  pend[WriteReg] <= 1'b0;
         if (iss_en) pend[IssueReg] <= 1'b1;
      end
   end

   // Outputs: done flag and the two combinational read ports.
   always_comb begin
      InitDone  = ready;
      ReadData1 = '0;
      ReadPend1 = 1'b0;
      ReadData2 = '0;
      ReadPend2 = 1'b0;
      if (ready && !(ZERO_EN && ReadReg1 == '0)) begin
         ReadData1 = mem[ReadReg1];
         ReadPend1 = pend[ReadReg1];
`ifdef REGFILE_BYPASS_EN
         if (RegWre && ReadReg1 == WriteReg) begin
            ReadData1 = WriteData;
            ReadPend1 = 1'b0;
         end
`endif
      end
      if (ready && !(ZERO_EN && ReadReg2 == '0)) begin
         ReadData2 = mem[ReadReg2];
         ReadPend2 = pend[ReadReg2];
`ifdef REGFILE_BYPASS_EN
         if (RegWre && ReadReg2 == WriteReg) begin
            ReadData2 = WriteData;
            ReadPend2 = 1'b0;
         end
`endif
      end
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated scoreboard and a post-reset initialisation sweep, for the MIPS pipeline decode stage. Two combinational read ports return data plus a per-operand pending flag, so hazard logic can stall on in-flight writes. Issue marks a destination pending and write-back clears it. After reset, the block clears every entry, one per cycle, before accepting traffic.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1: when 1, entry 0 reads as 0, is never written and is never pending.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- InitDone  out  1  1 when the sweep is complete and the block accepts traffic.
- RegWre  in  1  write-back enable.
- WriteReg  in  ADDR_W  write-back address.
- WriteData  in  DATA_W  write-back data.
- IssueValid  in  1  an instruction with a destination issues this cycle.
- IssueReg  in  ADDR_W  destination to mark pending.
- ReadReg1, ReadReg2  in  ADDR_W  read addresses.
- ReadData1, ReadData2  out  DATA_W  read data (combinational).
- ReadPend1, ReadPend2  out  1  operand has an outstanding write (combinational).

## Operation
- **State machine.** Two states: INIT and READY. A sweep counter `cnt` is ADDR_W bits wide.
- **Reset.** RST=0 at an edge:
  - Enter INIT with cnt=0.
  - Clear all pending bits.
  - InitDone=0.
  - Reset mid-operation behaves identically; in-progress sweeps restart from 0.
- **INIT.**
  - Each cycle, write 0 to entry cnt, clear pend[cnt] and increment cnt.
  - When cnt==DEPTH-1 is written, go to READY.
  - RegWre and IssueValid are ignored.
  - ReadData*=0 and ReadPend*=0.
- **READY.**
  - InitDone=1.
  - RegWre=1 writes WriteData to WriteReg and clears pend[WriteReg].
  - IssueValid=1 sets pend[IssueReg].
- **Simultaneous write-back and issue to the same register.** The write happens; pending ends set (the newer producer wins).
- **Register 0 (ZERO_REG=1).**
  - Writes to address 0 are dropped.
  - Issue to address 0 is dropped.
  - Reads of address 0 return 0 with pend 0.
- **Read ports.**
  - Both ports are independent and may alias each other, WriteReg or IssueReg.
  - Reads reflect stored state, subject to the bypass rule in Configuration.
  - The same-cycle IssueValid is not reflected until the next cycle.

## Timing
- The sweep takes exactly DEPTH cycles after RST deasserts. InitDone rises on the edge that writes entry DEPTH-1, i.e. it is 1 in cycle DEPTH counting the first post-reset cycle as 0.
- Reset values:
  - InitDone=0.
  - ReadData*=0.
  - ReadPend*=0.
  - Array contents are undefined until swept. The reset itself clears only pend; the sweep zeroes the array.
- Write latency: 1 edge. Stored data is visible on reads in the following cycle, or the same cycle with bypass.
- Pending set/clear latency: 1 edge.
- Read path: purely combinational, zero latency.

## Configuration
- REGFILE_BYPASS_EN:
  - **Defined.** When RegWre=1 in READY and ReadRegN==WriteReg (excluding register 0 when ZERO_REG=1):
    - ReadDataN=WriteData.
    - ReadPendN=0.
  - **Undefined.** Reads return stored array and pend values only; the write-back is visible the next cycle.

## Test plan
- **Sweep.** Hold RST=0 for 2 cycles, then release.
  - InitDone is 0 for cycles 0..DEPTH-1 and 1 at cycle DEPTH (32 with defaults).
  - Every ReadData=0.
  - Writes issued during INIT are lost.
- **Scoreboard.** In READY, IssueValid with IssueReg=5, then RegWre with WriteReg=5, WriteData=0xDEADBEEF one cycle later.
  - ReadPend1(5)=1 for one cycle, then 0.
  - ReadData1(5)=0xDEADBEEF afterwards.
- **Same-register collision.** Issue and write-back to reg 7 on the same edge with data 0x1234.
  - Next cycle: ReadData=0x1234 and ReadPend=1.
- **Register 0.** RegWre=1, WriteReg=0, WriteData=0xFFFFFFFF, together with IssueValid to reg 0.
  - ReadData(0)=0 and ReadPend(0)=0.
- **Bypass.** With REGFILE_BYPASS_EN, reg 9 pending, RegWre writes 0xA5A5A5A5 to reg 9 while ReadReg2=9.
  - Same cycle: ReadData2=0xA5A5A5A5 and ReadPend2=0.
  - Without the macro: old data and ReadPend2=1 that cycle, new values the next cycle.
- **Mid-operation reset.** Assert RST=0 with regs 3 and 4 pending and reg 3=0x55, then release.
  - InitDone returns to 0.
  - After the DEPTH-cycle sweep: reg 3 reads 0 and all pend flags are 0.
